// File: rtl/dooz_turn_scheduler.sv
// Sequences one 3x3 Dooz game: board ownership, turn order, move legality, bot handshake, per-turn timeout, win/draw.
// A legal strobe commits on its edge; the next side's turn flag rises 2 cycles after the strobe. The bot is held on bot_req until it acks.
module dooz_turn_scheduler #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  parameter bit FIRST_B        = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       botplay,
  input  logic [3:0] p1_move,
  input  logic       p1_valid,
  input  logic [3:0] p2_move,
  input  logic       p2_valid,
  output logic       bot_req,
  input  logic [3:0] bot_move,
  input  logic       bot_ack,
  output logic [8:0] board_occ,
  output logic [8:0] board_own,
  output logic       turn_a,
  output logic       turn_b,
  output logic       winner_a,
  output logic       winner_b,
  output logic       draw,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_BOT_REQ,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [8:0]       occ;
  logic [8:0]       own;
  logic [3:0]       move_cnt;
  logic [CNT_W-1:0] timer;
  logic             mode;
  logic             last_b;
  logic             win_a_q;
  logic             win_b_q;
  logic             draw_q;
  logic             illegal_q;
  logic             timeout_q;

  logic       in_turn;
  logic       mv_vld;
  logic [3:0] mv_cell;
  logic [3:0] mv_idx;
  logic       cell_ok;
  logic [8:0] cell_mask;
  logic       legal;
  logic       bad;
  logic       expire;
  logic       side_b;
  logic [8:0] mover_cells;
  logic       mover_won;
  state_t     opp_state;

  function automatic logic has_line(input logic [8:0] m);
    logic [8:0] lines [8];
    logic       hit;
    lines = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((m & lines[i]) == lines[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  assign in_turn = (state == S_WAIT_A) || (state == S_WAIT_B) || (state == S_BOT_REQ);
  assign side_b  = (state == S_WAIT_B) || (state == S_BOT_REQ);

  // Only the strobe belonging to the side whose turn it is gets through.
  always_comb begin
    mv_vld  = 1'b0;
    mv_cell = 4'd0;
    case (state)
      S_WAIT_A: begin
        mv_vld  = p1_valid;
        mv_cell = p1_move;
      end
      S_WAIT_B: begin
        mv_vld  = p2_valid;
        mv_cell = p2_move;
      end
      S_BOT_REQ: begin
        mv_vld  = bot_ack;
        mv_cell = bot_move;
      end
      default: begin
        mv_vld  = 1'b0;
        mv_cell = 4'd0;
      end
    endcase
  end

  assign cell_ok   = (mv_cell >= 4'd1) && (mv_cell <= 4'd9);
  assign mv_idx    = mv_cell - 4'd1;
  assign cell_mask = cell_ok ? (9'd1 << mv_idx) : 9'd0;
  assign legal     = mv_vld && cell_ok && ((occ & cell_mask) == 9'd0);
  assign bad       = mv_vld && !legal;
  // A legal commit on the expiry cycle takes precedence over the forfeit.
  assign expire    = in_turn && (timer == TIMER_LAST) && !legal;

  assign mover_cells = last_b ? (occ & own) : (occ & ~own);
  assign mover_won   = has_line(mover_cells);
  assign opp_state   = mode ? S_BOT_REQ : S_WAIT_B;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (!FIRST_B)     state_nxt = S_WAIT_A;
          else if (botplay) state_nxt = S_BOT_REQ;
          else              state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_A: begin
        if (legal)       state_nxt = S_CHECK;
        else if (expire) state_nxt = opp_state;
      end
      S_WAIT_B, S_BOT_REQ: begin
        if (legal)       state_nxt = S_CHECK;
        else if (expire) state_nxt = S_WAIT_A;
      end
      S_CHECK: begin
        if (mover_won || (move_cnt == 4'd9)) state_nxt = S_DONE;
        else if (last_b)                     state_nxt = S_WAIT_A;
        else                                 state_nxt = opp_state;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    turn_a  = 1'b0;
    turn_b  = 1'b0;
    bot_req = 1'b0;
    case (state)
      S_WAIT_A:  turn_a = 1'b1;
      S_WAIT_B:  turn_b = 1'b1;
      S_BOT_REQ: begin
        turn_b  = 1'b1;
        bot_req = 1'b1;
      end
      default: begin
        turn_a  = 1'b0;
        turn_b  = 1'b0;
        bot_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= 9'd0;
      own       <= 9'd0;
      move_cnt  <= 4'd0;
      timer     <= '0;
      mode      <= 1'b0;
      last_b    <= 1'b0;
      win_a_q   <= 1'b0;
      win_b_q   <= 1'b0;
      draw_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= bad;
      timeout_q <= expire;
      if (((state == S_IDLE) || (state == S_DONE)) && start) begin
        occ      <= 9'd0;
        own      <= 9'd0;
        move_cnt <= 4'd0;
        timer    <= '0;
        mode     <= botplay;
        last_b   <= 1'b0;
        win_a_q  <= 1'b0;
        win_b_q  <= 1'b0;
        draw_q   <= 1'b0;
      end else if (legal) begin
        occ    <= occ | cell_mask;
        own    <= side_b ? (own | cell_mask) : (own & ~cell_mask);
        last_b <= side_b;
        timer  <= '0;
        if (move_cnt != 4'd9) move_cnt <= move_cnt + 4'd1;
      end else if (expire) begin
        timer <= '0;
      end else if (in_turn) begin
        if (timer != '1) timer <= timer + 1'b1;
      end
      if (state == S_CHECK) begin
        if (mover_won) begin
          if (last_b) win_b_q <= 1'b1;
          else        win_a_q <= 1'b1;
        end else if (move_cnt == 4'd9) begin
          draw_q <= 1'b1;
        end
      end
    end
  end

  assign board_occ = occ;
  assign board_own = own;
  assign winner_a  = win_a_q;
  assign winner_b  = win_b_q;
  assign draw      = draw_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_dooz_turn_scheduler.sv
// Directed bench for dooz_turn_scheduler: vector table of moves plus hand sequences for timeout, bot handshake and async reset.
module tb_dooz_turn_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       botplay = 1'b0;
  logic [3:0] p1_move = 4'd0;
  logic       p1_valid = 1'b0;
  logic [3:0] p2_move = 4'd0;
  logic       p2_valid = 1'b0;
  logic       bot_req;
  logic [3:0] bot_move = 4'd0;
  logic       bot_ack = 1'b0;
  logic [8:0] board_occ;
  logic [8:0] board_own;
  logic       turn_a, turn_b, winner_a, winner_b, draw, illegal, timeout;

  int n_chk = 0;
  int n_fail = 0;

  dooz_turn_scheduler #(.TIMEOUT_CYCLES(8), .CNT_W(16), .FIRST_B(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .botplay(botplay),
    .p1_move(p1_move), .p1_valid(p1_valid), .p2_move(p2_move), .p2_valid(p2_valid),
    .bot_req(bot_req), .bot_move(bot_move), .bot_ack(bot_ack),
    .board_occ(board_occ), .board_own(board_own), .turn_a(turn_a), .turn_b(turn_b),
    .winner_a(winner_a), .winner_b(winner_b), .draw(draw), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // op: 0 = player A strobe, 1 = player B strobe, 2 = start, 3 = reset pulse
  typedef struct {
    int         op;
    logic [3:0] mv;
    logic       bp;
    logic       ill;
    logic [8:0] occ;
    logic [8:0] own;
    logic       ta;
    logic       tb;
    logic       wa;
    logic       wb;
    logic       dr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int op, input logic [3:0] mv, input logic bp, input logic ill,
                     input logic [8:0] occ, input logic [8:0] own,
                     input logic ta, input logic tb, input logic wa, input logic wb, input logic dr);
    vec_t v;
    v = '{op, mv, bp, ill, occ, own, ta, tb, wa, wb, dr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // game 1: A wins on the top row
    add(2, 0, 0, 0, 9'h000, 9'h000, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 9'h001, 9'h000, 0, 1, 0, 0, 0);
    add(1, 4, 0, 0, 9'h009, 9'h008, 1, 0, 0, 0, 0);
    add(0, 2, 0, 0, 9'h00B, 9'h008, 0, 1, 0, 0, 0);
    add(1, 5, 0, 0, 9'h01B, 9'h018, 1, 0, 0, 0, 0);
    add(0, 3, 0, 0, 9'h01F, 9'h018, 0, 0, 1, 0, 0);
    add(0, 9, 0, 0, 9'h01F, 9'h018, 0, 0, 1, 0, 0);
    // game 2: illegal moves, wrong-side strobe, reset mid-game
    add(2, 0, 0, 0, 9'h000, 9'h000, 1, 0, 0, 0, 0);
    add(0, 5, 0, 0, 9'h010, 9'h000, 0, 1, 0, 0, 0);
    add(1, 5, 0, 1, 9'h010, 9'h000, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 9'h010, 9'h000, 0, 1, 0, 0, 0);
    add(1, 10, 0, 1, 9'h010, 9'h000, 0, 1, 0, 0, 0);
    add(1, 2, 0, 0, 9'h012, 9'h002, 1, 0, 0, 0, 0);
    add(1, 3, 0, 0, 9'h012, 9'h002, 1, 0, 0, 0, 0);
    add(3, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0);
    // game 3: draw after nine moves
    add(2, 0, 0, 0, 9'h000, 9'h000, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 9'h001, 9'h000, 0, 1, 0, 0, 0);
    add(1, 2, 0, 0, 9'h003, 9'h002, 1, 0, 0, 0, 0);
    add(0, 3, 0, 0, 9'h007, 9'h002, 0, 1, 0, 0, 0);
    add(1, 5, 0, 0, 9'h017, 9'h012, 1, 0, 0, 0, 0);
    add(0, 4, 0, 0, 9'h01F, 9'h012, 0, 1, 0, 0, 0);
    add(1, 6, 0, 0, 9'h03F, 9'h032, 1, 0, 0, 0, 0);
    add(0, 8, 0, 0, 9'h0BF, 9'h032, 0, 1, 0, 0, 0);
    add(1, 7, 0, 0, 9'h0FF, 9'h072, 1, 0, 0, 0, 0);
    add(0, 9, 0, 0, 9'h1FF, 9'h072, 0, 0, 0, 0, 1);
    // game 4: restart from DONE, B wins on the middle row
    add(2, 0, 0, 0, 9'h000, 9'h000, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 9'h001, 9'h000, 0, 1, 0, 0, 0);
    add(1, 4, 0, 0, 9'h009, 9'h008, 1, 0, 0, 0, 0);
    add(0, 2, 0, 0, 9'h00B, 9'h008, 0, 1, 0, 0, 0);
    add(1, 5, 0, 0, 9'h01B, 9'h018, 1, 0, 0, 0, 0);
    add(0, 9, 0, 0, 9'h11B, 9'h018, 0, 1, 0, 0, 0);
    add(1, 6, 0, 0, 9'h13B, 9'h038, 0, 0, 0, 1, 0);

    // reset state
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst occ", board_occ, 9'h000);
    chk("rst own", board_own, 9'h000);
    chk("rst flags", {turn_a, turn_b, bot_req, winner_a, winner_b, draw, illegal, timeout}, 9'h000);
    reset = 1'b0;
    @(negedge clk);
    chk("idle flags", {turn_a, turn_b, bot_req, winner_a, winner_b, draw, illegal, timeout}, 9'h000);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        0: begin p1_move = vecs[i].mv; p1_valid = 1'b1; end
        1: begin p2_move = vecs[i].mv; p2_valid = 1'b1; end
        2: begin start = 1'b1; botplay = vecs[i].bp; end
        default: reset = 1'b1;
      endcase
      @(negedge clk);
      p1_valid = 1'b0;
      p2_valid = 1'b0;
      start = 1'b0;
      reset = 1'b0;
      chk($sformatf("v%0d illegal", i), illegal, vecs[i].ill);
      chk($sformatf("v%0d occ", i), board_occ, vecs[i].occ);
      chk($sformatf("v%0d own", i), board_own, vecs[i].own);
      chk($sformatf("v%0d timeout", i), timeout, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d illegal_end", i), illegal, 1'b0);
      chk($sformatf("v%0d turns", i), {turn_a, turn_b}, {vecs[i].ta, vecs[i].tb});
      chk($sformatf("v%0d result", i), {winner_a, winner_b, draw}, {vecs[i].wa, vecs[i].wb, vecs[i].dr});
    end

    // timeout: A idles, B idles, then A commits exactly on its expiry cycle
    start = 1'b1;
    botplay = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to A wait %0d", k), {timeout, turn_a}, 2'b01);
      @(negedge clk);
    end
    chk("to A pulse", timeout, 1'b1);
    chk("to A pass", turn_b, 1'b1);
    chk("to A occ", board_occ, 9'h000);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to B wait %0d", k), {timeout, turn_b}, 2'b01);
    end
    @(negedge clk);
    chk("to B pulse", {timeout, turn_a}, 2'b11);
    for (int k = 2; k <= 8; k++) @(negedge clk);
    p1_move = 4'd1;
    p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    chk("to commit no pulse", timeout, 1'b0);
    chk("to commit occ", board_occ, 9'h001);
    @(negedge clk);
    chk("to commit turn_b", {timeout, turn_b}, 2'b01);

    // bot mode handshake
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    botplay = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p1_move = 4'd1;
    p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    @(negedge clk);
    chk("bot req entry", {bot_req, turn_b}, 2'b11);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("bot req hold %0d", k), bot_req, 1'b1);
    end
    bot_move = 4'd1;
    bot_ack = 1'b1;
    @(negedge clk);
    bot_ack = 1'b0;
    chk("bot illegal", {illegal, bot_req}, 2'b11);
    chk("bot illegal occ", board_occ, 9'h001);
    bot_move = 4'd5;
    bot_ack = 1'b1;
    @(negedge clk);
    bot_ack = 1'b0;
    chk("bot ack drop", {illegal, bot_req}, 2'b00);
    chk("bot occ", board_occ, 9'h011);
    chk("bot own", board_own, 9'h010);
    @(negedge clk);
    chk("bot turn_a", {turn_a, bot_req}, 2'b10);
    p1_move = 4'd2;
    p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    @(negedge clk);
    chk("bot re-req", bot_req, 1'b1);

    // asynchronous reset mid-handshake
    #1 reset = 1'b1;
    #1;
    chk("arst bot_req", bot_req, 1'b0);
    chk("arst occ", board_occ, 9'h000);
    chk("arst own", board_own, 9'h000);
    chk("arst flags", {turn_a, turn_b, winner_a, winner_b, draw, illegal, timeout}, 9'h000);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    botplay = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("arst restart turn_a", turn_a, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
